// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: two-entry in-order skid buffer between the ALU and the
// register-file write port, with operand forwarding from buffered results.
module alu_result_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic [REG_W-1:0]  in_rd,
   input  logic              in_wen,
   input  logic              flush,
   output logic              rf_we,
   output logic [REG_W-1:0]  rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic              rf_ready,
   input  logic [REG_W-1:0]  fwd_rs1,
   input  logic [REG_W-1:0]  fwd_rs2,
   output logic              fwd_rs1_hit,
   output logic              fwd_rs2_hit,
   output logic [DATA_W-1:0] fwd_rs1_data,
   output logic [DATA_W-1:0] fwd_rs2_data,
   output logic [1:0]        occupancy
);

   typedef struct packed {
      logic              valid;
      logic              write;
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] result;
   } entry_t;

   // Slot 0 is always the head; slot 1 is only valid when slot 0 is.
   entry_t slot_q [2];
   entry_t slot_d [2];
   entry_t new_entry;
   logic   push;
   logic   pop;

   function automatic logic [DATA_W:0] lookup(input logic [REG_W-1:0] rs,
                                              input entry_t s0, input entry_t s1);
      logic [DATA_W:0] r;
      r = '0;
      if (s1.valid && s1.write && s1.rd == rs)
         r = {1'b1, s1.result};
      else if (s0.valid && s0.write && s0.rd == rs)
         r = {1'b1, s0.result};
      return r;
   endfunction

   always_comb begin
      in_ready  = !slot_q[1].valid;
      occupancy = {slot_q[1].valid, slot_q[0].valid & ~slot_q[1].valid};

      new_entry        = '0;
      new_entry.valid  = 1'b1;
      new_entry.write  = in_wen && (in_rd != '0);
      new_entry.rd     = in_rd;
      new_entry.result = in_result;

      push = in_valid && in_ready && !flush;
      pop  = slot_q[0].valid && !flush && (!slot_q[0].write || rf_ready);

      rf_we    = slot_q[0].valid && slot_q[0].write && !flush;
      rf_waddr = rf_we ? slot_q[0].rd : '0;
      rf_wdata = rf_we ? slot_q[0].result : '0;

      {fwd_rs1_hit, fwd_rs1_data} = lookup(fwd_rs1, slot_q[0], slot_q[1]);
      {fwd_rs2_hit, fwd_rs2_data} = lookup(fwd_rs2, slot_q[0], slot_q[1]);
   end

   // Retire shifts the younger entry to the head first, so a same-cycle push
   // lands in whichever slot is then free.
   always_comb begin
      slot_d[0] = slot_q[0];
      slot_d[1] = slot_q[1];
      if (flush) begin
         slot_d[0] = '0;
         slot_d[1] = '0;
      end else begin
         if (pop) begin
            slot_d[0] = slot_q[1];
            slot_d[1] = '0;
         end
         if (push) begin
            if (!slot_d[0].valid)
               slot_d[0] = new_entry;
            else
               slot_d[1] = new_entry;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q[0] <= '0;
         slot_q[1] <= '0;
      end else begin
         slot_q[0] <= slot_d[0];
         slot_q[1] <= slot_d[1];
      end
   end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: expected writes are queued as entries are
// accepted and retired against rf_we/rf_ready; directed checks cover occupancy and forwarding.
module tb_alu_result_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_wen, flush;
   logic [31:0] in_result;
   logic [4:0]  in_rd;
   logic        rf_we, rf_ready;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [4:0]  fwd_rs1, fwd_rs2;
   logic        fwd_rs1_hit, fwd_rs2_hit;
   logic [31:0] fwd_rs1_data, fwd_rs2_data;
   logic [1:0]  occupancy;

   int checks = 0;
   int errors = 0;
   logic [36:0] sb [$];
   logic        prev_stall = 1'b0;
   logic [36:0] prev_wr;

   always #5 clk = ~clk;

   alu_result_stage #(.DATA_W(32), .REG_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
      .in_rd(in_rd), .in_wen(in_wen), .flush(flush),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
      .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
      .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
      .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
      .occupancy(occupancy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one entry for the next edge; it is expected to be accepted there.
   task automatic drive(input logic [4:0] rd, input logic [31:0] data, input logic wen);
      in_valid  = 1'b1;
      in_rd     = rd;
      in_result = data;
      in_wen    = wen;
      if (wen && rd != 5'd0) sb.push_back({rd, data});
   endtask

   // Write-port monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rf_we) begin
            if (prev_stall) chk("stall_stable", {rf_waddr, rf_wdata}, prev_wr);
            if (rf_ready) begin
               if (sb.size() == 0) chk("wr_unexpected", rf_we, 1'b0);
               else chk("wr_data", {rf_waddr, rf_wdata}, sb.pop_front());
            end
         end else begin
            chk("idle_wport", {rf_waddr, rf_wdata}, 37'd0);
         end
         prev_stall = rf_we && !rf_ready;
         prev_wr    = {rf_waddr, rf_wdata};
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_rd = '0; in_wen = 1'b0;
      flush = 1'b0; rf_ready = 1'b1; fwd_rs1 = 5'd5; fwd_rs2 = 5'd0;
      tick(); tick();
      chk("rst_occ", occupancy, 2'd0);
      chk("rst_ready", in_ready, 1'b1);
      chk("rst_we", rf_we, 1'b0);
      chk("rst_hits", {fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data}, 34'd0);
      rst_n = 1'b1;
      tick();

      // Streaming, rf_ready high
      for (int i = 0; i < 3; i++) begin
         drive(5'(5 + i), 32'h11 * (i + 1), 1'b1);
         tick();
         chk("stream_occ", occupancy, 2'd1);
         chk("stream_lat", {rf_we, rf_waddr}, {1'b1, 5'(5 + i)});
      end
      in_valid = 1'b0;
      tick();
      chk("stream_empty", occupancy, 2'd0);

      // Backpressure
      rf_ready = 1'b0;
      drive(5'd3, 32'hA, 1'b1); tick();
      drive(5'd4, 32'hB, 1'b1); tick();
      chk("bp_occ2", occupancy, 2'd2);
      chk("bp_ready0", in_ready, 1'b0);
      chk("bp_head", {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd3, 32'hA});
      in_rd = 5'd13; in_result = 32'hC; in_wen = 1'b1;
      tick();
      chk("bp_held", {occupancy, rf_waddr}, {2'd2, 5'd3});
      rf_ready = 1'b1;
      tick();
      chk("bp_drop1", {occupancy, in_ready, rf_waddr}, {2'd1, 1'b1, 5'd4});
      sb.push_back({5'd13, 32'hC});
      tick();
      chk("bp_third", {occupancy, rf_waddr, rf_wdata}, {2'd1, 5'd13, 32'hC});
      in_valid = 1'b0;
      tick();
      chk("bp_empty", occupancy, 2'd0);

      // x0 and no-write entries retire without rf_ready
      rf_ready = 1'b0; fwd_rs1 = 5'd0; fwd_rs2 = 5'd9;
      drive(5'd0, 32'hDEAD, 1'b1); tick();
      chk("nw_occ_a", occupancy, 2'd1);
      chk("nw_a", {rf_we, fwd_rs1_hit, fwd_rs2_hit}, 3'b000);
      drive(5'd9, 32'h99, 1'b0); tick();
      chk("nw_occ_b", occupancy, 2'd1);
      chk("nw_b", {rf_we, fwd_rs1_hit, fwd_rs2_hit, fwd_rs2_data}, 35'd0);
      in_valid = 1'b0;
      tick();
      chk("nw_empty", occupancy, 2'd0);

      // Forwarding priority
      fwd_rs1 = 5'd8; fwd_rs2 = 5'd2;
      drive(5'd8, 32'h100, 1'b1); tick();
      chk("fwd_one", {fwd_rs1_hit, fwd_rs1_data}, {1'b1, 32'h100});
      drive(5'd8, 32'h200, 1'b1); tick();
      in_valid = 1'b0;
      #1;
      chk("fwd_occ2", occupancy, 2'd2);
      chk("fwd_young", {fwd_rs1_hit, fwd_rs1_data}, {1'b1, 32'h200});
      chk("fwd_miss", {fwd_rs2_hit, fwd_rs2_data}, 33'd0);
      rf_ready = 1'b1;
      tick();
      chk("fwd_after", {occupancy, fwd_rs1_hit, fwd_rs1_data}, {2'd1, 1'b1, 32'h200});
      tick();
      chk("fwd_gone", {occupancy, fwd_rs1_hit, fwd_rs1_data}, 35'd0);

      // Flush with two held entries and an incoming one
      rf_ready = 1'b0; fwd_rs1 = 5'd12;
      drive(5'd10, 32'h1, 1'b1); tick();
      drive(5'd11, 32'h2, 1'b1); tick();
      chk("fl_occ2", occupancy, 2'd2);
      sb.delete();
      in_rd = 5'd12; in_result = 32'h12; in_wen = 1'b1;
      flush = 1'b1; rf_ready = 1'b1;
      #1;
      chk("fl_we", rf_we, 1'b0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("fl_empty", {occupancy, in_ready, fwd_rs1_hit}, {2'd0, 1'b1, 1'b0});
      tick();
      chk("fl_nowrite", rf_we, 1'b0);

      // Asynchronous reset mid-drain
      rf_ready = 1'b0; fwd_rs1 = 5'd14;
      drive(5'd14, 32'h14, 1'b1); tick();
      drive(5'd15, 32'h15, 1'b1); tick();
      in_valid = 1'b0;
      chk("ar_occ2", occupancy, 2'd2);
      #2;
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("ar_state", {occupancy, rf_we, in_ready, fwd_rs1_hit, fwd_rs1_data},
          {2'd0, 1'b0, 1'b1, 1'b0, 32'd0});
      rf_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      tick(); tick();
      chk("ar_after", {occupancy, rf_we}, 3'd0);

      chk("sb_drain", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
